rr_port_arbiter: RTL and testbench
==================================

# rr_port_arbiter

Round-robin arbiter and registered output stage for one output port of a HNoC switch. It shares a single downstream valid/ready link among three input requesters: the top, bottom and inter-switch link ports of a switch node. Each flit carries a destination address, and only flits addressed to this port's range compete. It provides fair, starvation-free access at one flit per cycle and cuts the combinational path to the next switch with a one-flit output register.

## Interface
- DataWidth, 34, flit width; the destination address is in the MSBs.
- AddrWidth, 2, width of the address field, bits [DataWidth-1 : DataWidth-AddrWidth].
- DestMin, 0, lowest destination address routed to this port, inclusive.
- DestMax, 0, highest destination address routed to this port, inclusive.

- i_sclk  input  1  single clock; all state is updated on its rising edge.
- i_reset  input  1  reset, asynchronous and active-high.
- i_data0, i_data1, i_data2  input  DataWidth each  requester flits.
- i_data_valid0, i_data_valid1, i_data_valid2  input  1 each  requester valid.
- o_data_ready0, o_data_ready1, o_data_ready2  output  1 each  grant/accept per requester.
- o_data  output  DataWidth  registered output flit.
- o_data_valid  output  1  output flit valid.
- i_data_ready  input  1  downstream ready.

## Operation
- **Eligibility:** requester k is eligible when i_data_validk=1 and DestMin <= addr_k <= DestMax, where addr_k = i_datak[DataWidth-1 -: AddrWidth].
  - The comparison is unsigned.
  - If DestMin > DestMax, no requester is ever eligible.
  - An ineligible flit is ignored; its o_data_readyk stays 0.
- **Load condition:** load = !o_data_valid || i_data_ready. The output register is empty or being drained this cycle.
- **Priority pointer:** p in {0,1,2}. Priority order is p, p+1, p+2 (mod 3).
- **Grant:** when load=1 and at least one requester is eligible:
  - the first eligible requester g in priority order is granted;
  - o_data_readyg=1 combinationally in the same cycle; all other readies are 0;
  - on the clock edge: o_data <= i_datag, o_data_valid <= 1, p <= (g+1) mod 3.
- **No grant:** when load=1 and no requester is eligible, o_data_valid <= 0, and o_data and p hold.
- **Stall:** when load=0 (o_data_valid=1, i_data_ready=0):
  - all o_data_readyk are 0;
  - o_data, o_data_valid and p hold.
- **At most one grant per cycle:** o_data_ready0..2 are one-hot or all zero.
- **Handshake dependencies:** o_data_readyk depends combinationally on i_data_validk, i_datak, i_data_ready and state. There is no combinational path from any input to o_data or o_data_valid.
- **Data unchanged:** flits pass through unmodified, including the address bits.

## Timing
- **Reset (asynchronous):** o_data_valid=0, o_data=0, p=0, and all o_data_readyk are 0 while i_reset=1.
  - Reset mid-stream discards any held flit with no downstream transfer.
  - The first grant after release follows priority order 0,1,2.
- **Latency:** a flit accepted at edge N (o_data_readyg=1 in cycle N-1) appears on o_data with o_data_valid=1 in cycle N.
- **Throughput:** 1 flit/cycle with i_data_ready held at 1. Back-to-back flits need no bubble.
- **Simultaneous drain and load:** in a cycle with o_data_valid=1, i_data_ready=1 and an eligible requester, the downstream transfer and the new grant happen in the same cycle. The register is overwritten with the new flit.
- **Fairness:** with all three requesters eligible continuously and the downstream never stalling, grants rotate 0,1,2,0,1,2. Any continuously eligible requester is granted within 3 grant cycles.
- **Pointer wrap:** a grant to requester 2 sets p=0.
- **Backpressure:** o_data and o_data_valid remain stable while o_data_valid=1 and i_data_ready=0, for any number of cycles.

## Test plan
- **Reset:** assert i_reset during traffic.
  - Required: o_data_valid=0 and o_data=0 immediately, without waiting for a clock edge; all readies are 0.
  - After release, with requesters 1 and 2 valid: requester 1 is granted first (p=0, requester 0 idle).
- **Single flit** (DestMin=DestMax=0): i_data0=34'h0_1234_5678, valid for 1 cycle, i_data_ready=1.
  - Required: o_data_ready0=1 in that cycle; next cycle o_data=34'h0_1234_5678 and o_data_valid=1; the cycle after, o_data_valid=0.
- **Round-robin** (DestMin=0, DestMax=3): all three requesters valid for 6 cycles, i_data_ready=1.
  - Required: grant sequence 0,1,2,0,1,2; o_data_valid=1 for 6 consecutive cycles.
- **Backpressure:** load one flit, then hold i_data_ready=0 for 4 cycles while requester 1 is valid.
  - Required: o_data is stable, o_data_ready1=0 throughout.
  - When i_data_ready=1: o_data_ready1=1 in the same cycle, and the new flit appears next cycle.
- **Address filtering** (DestMin=DestMax=0): requester 1 sends address 2'b11, requester 0 sends address 2'b00.
  - Required: o_data_ready1 is never asserted; requester 0's flit is forwarded.
- **Empty range:** configure DestMin=2, DestMax=1 and make all requesters valid.
  - Required: no ready is ever asserted; o_data_valid stays 0.

Source files
------------

// File: rtl/rr_port_arbiter_if.sv
// Handshake bundle for one arbitrated output port: three requesters in,
// one registered valid/ready link out.
interface rr_port_arbiter_if #(
  parameter int DataWidth = 34
);
  logic [DataWidth-1:0] i_data0;
  logic [DataWidth-1:0] i_data1;
  logic [DataWidth-1:0] i_data2;
  logic                 i_data_valid0;
  logic                 i_data_valid1;
  logic                 i_data_valid2;
  logic                 o_data_ready0;
  logic                 o_data_ready1;
  logic                 o_data_ready2;
  logic [DataWidth-1:0] o_data;
  logic                 o_data_valid;
  logic                 i_data_ready;

  // arbiter side
  modport slave (
    input  i_data0, i_data1, i_data2,
    input  i_data_valid0, i_data_valid1, i_data_valid2,
    output o_data_ready0, o_data_ready1, o_data_ready2,
    output o_data, o_data_valid,
    input  i_data_ready
  );

  // requester / downstream side
  modport master (
    output i_data0, i_data1, i_data2,
    output i_data_valid0, i_data_valid1, i_data_valid2,
    input  o_data_ready0, o_data_ready1, o_data_ready2,
    input  o_data, o_data_valid,
    output i_data_ready
  );
endinterface

// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter over three requesters feeding a one-flit output register.
// Only flits whose destination address falls in [DestMin, DestMax] compete.
module rr_port_arbiter #(
  parameter int DataWidth = 34,
  parameter int AddrWidth = 2,
  parameter int DestMin   = 0,
  parameter int DestMax   = 0
) (
  input  logic                i_sclk,
  input  logic                i_reset,
  rr_port_arbiter_if.slave    bus
);

  logic [DataWidth-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic [1:0]           ptr_q, ptr_d;

  logic [DataWidth-1:0] din [3];
  logic [2:0]           vld;
  logic [2:0]           elig;
  logic [1:0]           gnt;
  logic                 any;
  logic                 load;
  logic                 grant_en;

  assign din[0] = bus.i_data0;
  assign din[1] = bus.i_data1;
  assign din[2] = bus.i_data2;
  assign vld    = {bus.i_data_valid2, bus.i_data_valid1, bus.i_data_valid0};

  // Signed int compare keeps the range check clean when DestMin is 0.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      elig[k] = vld[k]
              && (int'(din[k][DataWidth-1 -: AddrWidth]) >= DestMin)
              && (int'(din[k][DataWidth-1 -: AddrWidth]) <= DestMax);
    end
  end

  function automatic logic [1:0] rot(input logic [1:0] p, input logic [1:0] j);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, j};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Walk from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    logic [1:0] idx;
    gnt = 2'd0;
    any = 1'b0;
    idx = 2'd0;
    for (int j = 2; j >= 0; j--) begin
      idx = rot(ptr_q, 2'(j));
      if (elig[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end

  assign load     = !valid_q || bus.i_data_ready;
  assign grant_en = !i_reset && load && any;

  assign bus.o_data_ready0 = grant_en && (gnt == 2'd0);
  assign bus.o_data_ready1 = grant_en && (gnt == 2'd1);
  assign bus.o_data_ready2 = grant_en && (gnt == 2'd2);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (any) begin
        data_d  = din[gnt];
        valid_d = 1'b1;
        ptr_d   = (gnt == 2'd2) ? 2'd0 : 2'(gnt + 2'd1);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= 2'd0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed bench: three arbiter instances with different destination ranges
// (0..0, 0..3, empty 2..1), a vector table plus hand-written corner sequences.
module tb_rr_port_arbiter;

  localparam logic [33:0] D0 = 34'h0_0000_00A0;
  localparam logic [33:0] D1 = 34'h1_0000_00B1;
  localparam logic [33:0] D2 = 34'h3_0000_00C2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_port_arbiter_if #(.DataWidth(34)) if_a ();
  rr_port_arbiter_if #(.DataWidth(34)) if_b ();
  rr_port_arbiter_if #(.DataWidth(34)) if_c ();

  rr_port_arbiter #(.DataWidth(34), .AddrWidth(2), .DestMin(0), .DestMax(0))
    u_a (.i_sclk(clk), .i_reset(rst), .bus(if_a));
  rr_port_arbiter #(.DataWidth(34), .AddrWidth(2), .DestMin(0), .DestMax(3))
    u_b (.i_sclk(clk), .i_reset(rst), .bus(if_b));
  rr_port_arbiter #(.DataWidth(34), .AddrWidth(2), .DestMin(2), .DestMax(1))
    u_c (.i_sclk(clk), .i_reset(rst), .bus(if_c));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  v;
    logic        rdy;
    logic [2:0]  exp_rdy;
    logic        exp_ov;
    logic [33:0] exp_od;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [2:0] rdy_b();
    return {if_b.o_data_ready2, if_b.o_data_ready1, if_b.o_data_ready0};
  endfunction

  function automatic logic [2:0] rdy_a();
    return {if_a.o_data_ready2, if_a.o_data_ready1, if_a.o_data_ready0};
  endfunction

  function automatic logic [2:0] rdy_c();
    return {if_c.o_data_ready2, if_c.o_data_ready1, if_c.o_data_ready0};
  endfunction

  task automatic drive_b(input logic [2:0] v, input logic r);
    if_b.i_data_valid0 = v[0];
    if_b.i_data_valid1 = v[1];
    if_b.i_data_valid2 = v[2];
    if_b.i_data_ready  = r;
  endtask

  initial begin
    // full-range table: rotation, idle, backpressure, partial request sets
    tbl[0]  = '{3'b111, 1'b1, 3'b001, 1'b1, D0};
    tbl[1]  = '{3'b111, 1'b1, 3'b010, 1'b1, D1};
    tbl[2]  = '{3'b111, 1'b1, 3'b100, 1'b1, D2};
    tbl[3]  = '{3'b111, 1'b1, 3'b001, 1'b1, D0};
    tbl[4]  = '{3'b111, 1'b1, 3'b010, 1'b1, D1};
    tbl[5]  = '{3'b111, 1'b1, 3'b100, 1'b1, D2};
    tbl[6]  = '{3'b000, 1'b1, 3'b000, 1'b0, D2};
    tbl[7]  = '{3'b110, 1'b0, 3'b010, 1'b1, D1};
    tbl[8]  = '{3'b110, 1'b0, 3'b000, 1'b1, D1};
    tbl[9]  = '{3'b110, 1'b0, 3'b000, 1'b1, D1};
    tbl[10] = '{3'b110, 1'b1, 3'b100, 1'b1, D2};
    tbl[11] = '{3'b011, 1'b1, 3'b001, 1'b1, D0};
    tbl[12] = '{3'b101, 1'b1, 3'b100, 1'b1, D2};
    tbl[13] = '{3'b010, 1'b1, 3'b010, 1'b1, D1};
    tbl[14] = '{3'b001, 1'b1, 3'b001, 1'b1, D0};
    tbl[15] = '{3'b000, 1'b0, 3'b000, 1'b1, D0};
    tbl[16] = '{3'b000, 1'b1, 3'b000, 1'b0, D0};

    if_a.i_data0 = '0; if_a.i_data1 = '0; if_a.i_data2 = '0;
    if_a.i_data_valid0 = 0; if_a.i_data_valid1 = 0; if_a.i_data_valid2 = 0;
    if_a.i_data_ready = 0;
    if_b.i_data0 = D0; if_b.i_data1 = D1; if_b.i_data2 = D2;
    drive_b(3'b111, 1'b1);
    if_c.i_data0 = 34'h1_0000_0011; if_c.i_data1 = 34'h2_0000_0022;
    if_c.i_data2 = 34'h0_0000_0033;
    if_c.i_data_valid0 = 0; if_c.i_data_valid1 = 0; if_c.i_data_valid2 = 0;
    if_c.i_data_ready = 0;

    // reset state, readies held low even with requests pending
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ov_a", if_a.o_data_valid, 1'b0);
    chk("reset_od_b", if_b.o_data, 34'h0);
    chk("reset_ov_b", if_b.o_data_valid, 1'b0);
    chk("reset_rdy_b", rdy_b(), 3'b000);
    chk("reset_ov_c", if_c.o_data_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      if (i != 0) @(negedge clk);
      drive_b(tbl[i].v, tbl[i].rdy);
      #1;
      chk($sformatf("tbl%0d_rdy", i), rdy_b(), tbl[i].exp_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_ov", i), if_b.o_data_valid, tbl[i].exp_ov);
      chk($sformatf("tbl%0d_od", i), if_b.o_data, tbl[i].exp_od);
    end

    // single flit through the 0..0 port
    @(negedge clk);
    if_a.i_data0 = 34'h0_1234_5678;
    if_a.i_data_valid0 = 1;
    if_a.i_data_ready = 1;
    #1;
    chk("single_rdy", rdy_a(), 3'b001);
    @(posedge clk); #1;
    chk("single_od", if_a.o_data, 34'h0_1234_5678);
    chk("single_ov", if_a.o_data_valid, 1'b1);
    @(negedge clk);
    if_a.i_data_valid0 = 0;
    @(posedge clk); #1;
    chk("single_ov_drop", if_a.o_data_valid, 1'b0);

    // address filtering: requester 1 targets address 3, out of range
    @(negedge clk);
    if_a.i_data0 = 34'h0_0000_0055;
    if_a.i_data1 = 34'h3_0000_0066;
    if_a.i_data_valid0 = 1;
    if_a.i_data_valid1 = 1;
    #1;
    chk("filt_rdy", rdy_a(), 3'b001);
    @(posedge clk); #1;
    chk("filt_od", if_a.o_data, 34'h0_0000_0055);
    @(negedge clk);
    if_a.i_data_valid0 = 0;
    #1;
    chk("filt_rdy1_alone", rdy_a(), 3'b000);
    @(posedge clk); #1;
    chk("filt_ov_drop", if_a.o_data_valid, 1'b0);
    @(negedge clk);
    if_a.i_data_valid1 = 0;

    // empty destination range never grants
    if_c.i_data_valid0 = 1; if_c.i_data_valid1 = 1; if_c.i_data_valid2 = 1;
    if_c.i_data_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("empty%0d_rdy", i), rdy_c(), 3'b000);
      @(posedge clk); #1;
      chk($sformatf("empty%0d_ov", i), if_c.o_data_valid, 1'b0);
      @(negedge clk);
    end

    // asynchronous reset mid-stream; pointer was 1 before this grant
    drive_b(3'b111, 1'b1);
    @(posedge clk); #1;
    chk("prereset_od", if_b.o_data, D1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_ov", if_b.o_data_valid, 1'b0);
    chk("async_od", if_b.o_data, 34'h0);
    chk("async_rdy", rdy_b(), 3'b000);
    @(negedge clk);
    rst = 1'b0;
    drive_b(3'b110, 1'b1);
    #1;
    chk("postreset_rdy", rdy_b(), 3'b010);
    @(posedge clk); #1;
    chk("postreset_od", if_b.o_data, D1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
